message_tx_serializer: RTL and testbench



---
 rtl/message_tx_serializer.sv | 136 +++++++++++++
 tb/tb_message_tx_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/message_tx_serializer.sv
// Frames a latched MSG_LENGTH-bit message as SOF + payload bytes (MSB first) on a valid/ready byte stream.
// Optional trailing CRC-8 byte when MSG_TX_CRC_EN is defined.
module message_tx_serializer #(
    parameter int unsigned           MSG_LENGTH = 48,
    parameter int unsigned           BYTE_WIDTH = 8,
    parameter logic [BYTE_WIDTH-1:0] SOF_BYTE   = BYTE_WIDTH'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  rsnt,
    input  logic                  send_data,
    input  logic [MSG_LENGTH-1:0] tx_data,
    output logic                  data_sent,
    output logic                  busy,
    output logic [BYTE_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [7:0]            overrun_count
);

    localparam int unsigned     N        = MSG_LENGTH / BYTE_WIDTH;
    localparam int unsigned     IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef MSG_TX_CRC_EN
    typedef enum logic [2:0] {IDLE, SOF, DATA, CRC, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SOF, DATA, DONE} state_t;
`endif

    state_t                state;
    logic [MSG_LENGTH-1:0] shreg;
    logic [IDX_W-1:0]      idx;

`ifdef MSG_TX_CRC_EN
    logic [7:0] crc;

    // CRC-8, poly 0x07, MSB first, no reflection or final XOR
    function automatic logic [7:0] crc8_update(input logic [7:0] c_in,
                                               input logic [BYTE_WIDTH-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = int'(BYTE_WIDTH) - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or posedge rsnt) begin
        if (rsnt) begin
            state         <= IDLE;
            shreg         <= '0;
            idx           <= '0;
            data_sent     <= 1'b0;
            busy          <= 1'b0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            overrun_count <= '0;
`ifdef MSG_TX_CRC_EN
            crc           <= '0;
`endif
        end else begin
            // Requests outside IDLE (including the DONE cycle) are dropped and counted
            if (send_data && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            case (state)
                IDLE: begin
                    if (send_data) begin
                        shreg      <= tx_data;
                        idx        <= '0;
                        busy       <= 1'b1;
                        byte_valid <= 1'b1;
                        byte_data  <= SOF_BYTE;
                        state      <= SOF;
`ifdef MSG_TX_CRC_EN
                        crc        <= '0;
`endif
                    end
                end

                // byte_data is preloaded with the next byte so it is registered at the port
                SOF: begin
                    if (byte_ready) begin
                        byte_data <= shreg[MSG_LENGTH-1 -: BYTE_WIDTH];
                        shreg     <= shreg << BYTE_WIDTH;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (byte_ready) begin
`ifdef MSG_TX_CRC_EN
                        crc <= crc8_update(crc, byte_data);
`endif
                        if (idx == LAST_IDX) begin
`ifdef MSG_TX_CRC_EN
                            byte_data <= BYTE_WIDTH'(crc8_update(crc, byte_data));
                            state     <= CRC;
`else
                            byte_valid <= 1'b0;
                            data_sent  <= 1'b1;
                            state      <= DONE;
`endif
                        end else begin
                            byte_data <= shreg[MSG_LENGTH-1 -: BYTE_WIDTH];
                            shreg     <= shreg << BYTE_WIDTH;
                            idx       <= idx + IDX_W'(1);
                        end
                    end
                end

`ifdef MSG_TX_CRC_EN
                CRC: begin
                    if (byte_ready) begin
                        byte_valid <= 1'b0;
                        data_sent  <= 1'b1;
                        state      <= DONE;
                    end
                end
`endif

                DONE: begin
                    data_sent <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_tx_serializer.sv
// Directed bench for message_tx_serializer: queue-based frame model checked every cycle plus literal pins.
module tb_message_tx_serializer;

    localparam int unsigned N = 6;
`ifdef MSG_TX_CRC_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rsnt;
    logic        send_data;
    logic [47:0] tx_data;
    logic        data_sent;
    logic        busy;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  overrun_count;

    message_tx_serializer dut (
        .clk           (clk),
        .rsnt          (rsnt),
        .send_data     (send_data),
        .tx_data       (tx_data),
        .data_sent     (data_sent),
        .busy          (busy),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef MSG_TX_CRC_EN
    function automatic logic [7:0] crc8(input logic [47:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 47; b >= 0; b--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[b]) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    // Model: a frame is a queue of bytes still owed; done follows the last pop by one cycle
    logic [7:0] mq[$];
    bit         m_done = 1'b0;
    int         m_ovr  = 0;

    always @(negedge clk) begin
        bit m_busy;
        bit nd;
        if (rsnt) begin
            chk("rst_valid", 64'(byte_valid), 64'(0));
            chk("rst_sent", 64'(data_sent), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_byte", 64'(byte_data), 64'(0));
            chk("rst_ovr", 64'(overrun_count), 64'(0));
            mq.delete();
            m_done = 1'b0;
            m_ovr  = 0;
        end else begin
            m_busy = (mq.size() != 0) || m_done;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("data_sent", 64'(data_sent), 64'(m_done));
            chk("byte_valid", 64'(byte_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) chk("byte_data", 64'(byte_data), 64'(mq[0]));
            chk("overrun_count", 64'(overrun_count), 64'(m_ovr));
            nd = 1'b0;
            if (send_data) begin
                if (!m_busy) begin
                    mq.push_back(8'hA5);
                    for (int i = 0; i < int'(N); i++) mq.push_back(tx_data[47-8*i -: 8]);
`ifdef MSG_TX_CRC_EN
                    mq.push_back(crc8(tx_data));
`endif
                end else if (m_ovr < 255) begin
                    m_ovr++;
                end
            end
            if (m_busy && mq.size() != 0 && byte_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) nd = 1'b1;
            end
            m_done = nd;
        end
    end

    logic [7:0] byte_at [0:47];
    bit         valid_at[0:47];
    int         sent_at;

    // Caller is #1 after a posedge; that cycle is cycle 0 of the frame
    task automatic send_frame(input logic [47:0] d, input int stall_start, input int stall_len,
                              input int ovr_a, input int ovr_b);
        send_data  = 1'b1;
        tx_data    = d;
        byte_ready = 1'b1;
        sent_at    = -1;
        for (int c = 0; c < 40 && sent_at < 0; c++) begin
            @(negedge clk);
            byte_at[c]  = byte_data;
            valid_at[c] = byte_valid;
            if (data_sent) sent_at = c;
            @(posedge clk);
            #1;
            send_data  = (c + 1 == ovr_a) || (c + 1 == ovr_b);
            tx_data    = send_data ? 48'hFFFF_FFFF_FFFF : d;
            byte_ready = !((c + 1 >= stall_start) && (c + 1 < stall_start + stall_len));
        end
        send_data  = 1'b0;
        byte_ready = 1'b1;
        if (sent_at < 0) chk("frame_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        int seen;
        rsnt       = 1'b1;
        send_data  = 1'b0;
        tx_data    = '0;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_valid", 64'(byte_valid), 64'(0));
        chk("lit_rst_ovr", 64'(overrun_count), 64'(0));
        rsnt = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame
        send_frame(48'h0123_4567_89AB, -1, 0, -1, -1);
        chk("basic_b1", 64'(byte_at[1]), 64'hA5);
        chk("basic_b2", 64'(byte_at[2]), 64'h01);
        chk("basic_b7", 64'(byte_at[7]), 64'hAB);
        chk("basic_v7", 64'(valid_at[7]), 64'(1));
        chk("basic_sent", 64'(sent_at), 64'(8 + EXTRA));
        @(posedge clk);
        #1;

        // Backpressure on byte 0x45 for 3 cycles
        send_frame(48'h0123_4567_89AB, 4, 3, -1, -1);
        for (int c = 4; c <= 7; c++) chk("bp_hold", 64'(byte_at[c]), 64'h45);
        chk("bp_b8", 64'(byte_at[8]), 64'h67);
        chk("bp_sent", 64'(sent_at), 64'(11 + EXTRA));
        @(posedge clk);
        #1;

        // Overruns at cycles 3 and 5, then back-to-back frame
        send_frame(48'h0123_4567_89AB, -1, 0, 3, 5);
        chk("ovr_b3", 64'(byte_at[3]), 64'h23);
        chk("ovr_b7", 64'(byte_at[7]), 64'hAB);
        chk("ovr_count", 64'(overrun_count), 64'(2));
        send_frame(48'hDEAD_BEEF_0042, -1, 0, -1, -1);
        chk("b2b_b1", 64'(byte_at[1]), 64'hA5);
        chk("b2b_b2", 64'(byte_at[2]), 64'hDE);
        chk("b2b_sent", 64'(sent_at), 64'(8 + EXTRA));
        chk("b2b_ovr", 64'(overrun_count), 64'(2));

        // All-zero payload; CRC byte of zeros is zero
        send_frame(48'h0, -1, 0, -1, -1);
        chk("zero_b6", 64'(byte_at[6]), 64'h00);
        chk("zero_v8", 64'(valid_at[8]), 64'(EXTRA));
        chk("zero_sent", 64'(sent_at), 64'(8 + EXTRA));
        @(posedge clk);
        #1;

        // Saturation: frame stalled on SOF while 300 requests arrive
        send_data  = 1'b1;
        tx_data    = 48'h1111_2222_3333;
        byte_ready = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            send_data = 1'b1;
        end
        @(posedge clk);
        #1;
        send_data = 1'b0;
        @(negedge clk);
        chk("sat_ovr", 64'(overrun_count), 64'(255));
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (data_sent) seen = 1;
        end
        chk("sat_done", 64'(seen), 64'(1));
        chk("sat_ovr_hold", 64'(overrun_count), 64'(255));
        @(posedge clk);
        #1;

        // Reset while 0x45 is on the bus
        send_data = 1'b1;
        tx_data   = 48'h0123_4567_89AB;
        @(posedge clk);
        #1;
        send_data = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_byte", 64'(byte_data), 64'h45);
        rsnt = 1'b1;
        #1;
        chk("async_valid", 64'(byte_valid), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rsnt = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (data_sent) seen++;
        end
        chk("rst_no_sent", 64'(seen), 64'(0));
        chk("rst_ovr_clr", 64'(overrun_count), 64'(0));
        @(posedge clk);
        #1;
        send_frame(48'h0123_4567_89AB, -1, 0, -1, -1);
        chk("post_rst_b1", 64'(byte_at[1]), 64'hA5);
        chk("post_rst_b2", 64'(byte_at[2]), 64'h01);
        chk("post_rst_sent", 64'(sent_at), 64'(8 + EXTRA));
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
